fft_sweep_control: RTL
======================

FFT_SWEEP_CONTROL -- requirements
Module: fft_sweep_control

Interface
REQ-001 SHALL have parameter ADDR_W, default 11: sample/ROM address width.
REQ-002 SHALL have parameter NPTS, default 8: frequency points per sweep (2..256).
REQ-003 SHALL have parameter RST_CYC, default 2: fft_reset high time per point, in cycles (>=1).
REQ-004 SHALL have parameter TMO_CYC, default 4096: per-point wait limit, in cycles.
REQ-005 SHALL have ports, in this order:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- sweep_start  in  1  one-cycle request to begin a sweep.
- continuous  in  1  sampled at sweep start; 1 = restart after the last point.
- abort  in  1  stop the sweep and return to IDLE.
- addr_base  in  ADDR_W  start address of point 0.
- addr_step  in  ADDR_W  address increment per point.
- en_start  in  1  FFT result-ready strobe for the current point.
- fft_reset  out  1  FFT core reset.
- reg_addr  out  ADDR_W  latched start address of the current point.
- pt_idx  out  clog2(NPTS)  current point index.
- pt_done  out  1  one-cycle pulse when a point completes.
- busy  out  1  high in any state except IDLE.
- sweep_done  out  1  one-cycle pulse after the last point.
- tmo_err  out  1  sticky timeout flag.

Function
REQ-006 SHALL implement the states IDLE, LOAD, RESET, WAIT, NEXT.
REQ-007 IDLE: fft_reset=0; on sweep_start, latch addr_base, addr_step and continuous, set pt_idx=0, clear tmo_err, go to LOAD.
REQ-008 LOAD: reg_addr <= addr_base + pt_idx*addr_step, truncated modulo 2^ADDR_W; go to RESET next cycle.
REQ-009 RESET: fft_reset=1 for exactly RST_CYC cycles, then WAIT.
REQ-010 WAIT: fft_reset=0; en_start in WAIT -> NEXT; en_start in any other state SHALL be ignored.
REQ-011 NEXT: pt_done pulses for 1 cycle.
- If pt_idx<NPTS-1: pt_idx+1, go to LOAD.
- Otherwise: sweep_done pulses in the same cycle; if continuous, pt_idx=0 and go to LOAD, else go to IDLE.
REQ-012 SHALL hold reg_addr stable from LOAD exit until the next LOAD.
REQ-013 Latency from sweep_start to fft_reset rise: 2 cycles. Latency from en_start to the next point's fft_reset rise: 3 cycles.
REQ-014 abort in any non-IDLE state SHALL reach IDLE next cycle with fft_reset=0, no pt_done and no sweep_done; abort has priority over en_start.
REQ-015 sweep_start while busy SHALL be ignored.
REQ-016 addr_base, addr_step and continuous SHALL be sampled only in IDLE; later changes have no effect until the next sweep.

Reset
REQ-017 On rst=1 at a clock edge: state=IDLE, fft_reset=0, reg_addr=0, pt_idx=0, pt_done=0, busy=0, sweep_done=0, tmo_err=0.
REQ-018 rst SHALL override abort and all other inputs, including mid-sweep.

Configuration
REQ-019 With FFT_SWEEP_TIMEOUT_EN defined: a cycle counter runs in WAIT; after TMO_CYC cycles without en_start, tmo_err <= 1 and the FSM goes to NEXT as if the point completed.
REQ-020 Without FFT_SWEEP_TIMEOUT_EN: no counter; WAIT holds indefinitely; tmo_err stays 0.

Structure
REQ-021 SHALL place the state encoding, the state typedef and the default parameter constants in package fft_sweep_pkg.
REQ-022 SHALL be a single module; the timeout counter SHALL be inline logic, not a sub-module.

Verification
REQ-023 Base sweep: NPTS=4, base=100, step=256, continuous=0, en_start 10 cycles after each WAIT entry -> reg_addr 100, 356, 612, 868; four pt_done pulses; one sweep_done; busy falls the cycle after.
REQ-024 Wrap: base=2000, step=100, ADDR_W=11 -> the second reg_addr is 52.
REQ-025 Abort during RESET of point 2 -> IDLE next cycle, fft_reset=0, no sweep_done; a new sweep_start restarts at pt_idx 0.
REQ-026 continuous=1 -> after point NPTS-1, sweep_done pulses and the next LOAD uses pt_idx=0 with reg_addr=base.
REQ-027 Timeout enabled with TMO_CYC=16, en_start never asserted -> tmo_err set 16 cycles into the first WAIT, pt_idx advances, sweep completes.
REQ-028 Stray input: en_start pulsed during RESET, and rst asserted mid-WAIT -> en_start ignored; all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/fft_sweep_pkg.sv
// Shared state encoding and default parameters for fft_sweep_control.
package fft_sweep_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RESET = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4
  } sweep_state_e;

  localparam int DEF_ADDR_W  = 11;
  localparam int DEF_NPTS    = 8;
  localparam int DEF_RST_CYC = 2;
  localparam int DEF_TMO_CYC = 4096;

endpackage

// File: rtl/fft_sweep_control.sv
// Steps an FFT core through NPTS frequency points: load address, pulse reset, await result.
// Define FFT_SWEEP_TIMEOUT_EN to add a per-point WAIT timeout that sets tmo_err and advances.
module fft_sweep_control
  import fft_sweep_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NPTS    = DEF_NPTS,
  parameter int RST_CYC = DEF_RST_CYC,
  parameter int TMO_CYC = DEF_TMO_CYC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sweep_start,
  input  logic                     continuous,
  input  logic                     abort,
  input  logic [ADDR_W-1:0]        addr_base,
  input  logic [ADDR_W-1:0]        addr_step,
  input  logic                     en_start,
  output logic                     fft_reset,
  output logic [ADDR_W-1:0]        reg_addr,
  output logic [$clog2(NPTS)-1:0]  pt_idx,
  output logic                     pt_done,
  output logic                     busy,
  output logic                     sweep_done,
  output logic                     tmo_err
);

  localparam int PT_W = $clog2(NPTS);
  localparam int RC_W = $clog2(RST_CYC + 1);
  localparam logic [PT_W-1:0] LAST_PT = PT_W'(NPTS - 1);

  sweep_state_e      state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, step_q, step_d, reg_addr_q, reg_addr_d;
  logic              cont_q, cont_d;
  logic [PT_W-1:0]   pt_idx_q, pt_idx_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic              tmo_err_q, tmo_err_d;
  logic              fft_reset_q, fft_reset_d, pt_done_q, pt_done_d;
  logic              busy_q, busy_d, sweep_done_q, sweep_done_d;

`ifdef FFT_SWEEP_TIMEOUT_EN
  localparam int TC_W = $clog2(TMO_CYC + 1);
  logic [TC_W-1:0]   tcnt_q, tcnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    step_d     = step_q;
    cont_d     = cont_q;
    pt_idx_d   = pt_idx_q;
    reg_addr_d = reg_addr_q;
    rcnt_d     = rcnt_q;
    tmo_err_d  = tmo_err_q;
`ifdef FFT_SWEEP_TIMEOUT_EN
    tcnt_d     = tcnt_q;
`endif

    unique case (state_q)
      S_IDLE: if (sweep_start) begin
        base_d    = addr_base;
        step_d    = addr_step;
        cont_d    = continuous;
        pt_idx_d  = '0;
        tmo_err_d = 1'b0;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        // Truncation to ADDR_W gives the modulo-2^ADDR_W wrap for free.
        reg_addr_d = base_q + step_q * ADDR_W'(pt_idx_q);
        rcnt_d     = '0;
        state_d    = S_RESET;
      end
      S_RESET: begin
        if (rcnt_q == RC_W'(RST_CYC - 1)) begin
          state_d = S_WAIT;
`ifdef FFT_SWEEP_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (en_start) begin
          state_d = S_NEXT;
        end
`ifdef FFT_SWEEP_TIMEOUT_EN
        else if (tcnt_q == TC_W'(TMO_CYC - 1)) begin
          tmo_err_d = 1'b1;
          state_d   = S_NEXT;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
`endif
      end
      S_NEXT: begin
        if (pt_idx_q != LAST_PT) begin
          pt_idx_d = pt_idx_q + 1'b1;
          state_d  = S_LOAD;
        end else if (cont_q) begin
          pt_idx_d = '0;
          state_d  = S_LOAD;
        end else begin
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort beats en_start and any timeout that lands in the same cycle.
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      pt_idx_d  = pt_idx_q;
      tmo_err_d = tmo_err_q;
    end

    // Outputs are registered off the next state so they line up with it.
    fft_reset_d  = (state_d == S_RESET);
    busy_d       = (state_d != S_IDLE);
    pt_done_d    = (state_d == S_NEXT);
    sweep_done_d = (state_d == S_NEXT) && (pt_idx_q == LAST_PT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      step_q       <= '0;
      cont_q       <= 1'b0;
      pt_idx_q     <= '0;
      reg_addr_q   <= '0;
      rcnt_q       <= '0;
      tmo_err_q    <= 1'b0;
      fft_reset_q  <= 1'b0;
      busy_q       <= 1'b0;
      pt_done_q    <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      step_q       <= step_d;
      cont_q       <= cont_d;
      pt_idx_q     <= pt_idx_d;
      reg_addr_q   <= reg_addr_d;
      rcnt_q       <= rcnt_d;
      tmo_err_q    <= tmo_err_d;
      fft_reset_q  <= fft_reset_d;
      busy_q       <= busy_d;
      pt_done_q    <= pt_done_d;
      sweep_done_q <= sweep_done_d;
    end
  end

`ifdef FFT_SWEEP_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) tcnt_q <= '0;
    else     tcnt_q <= tcnt_d;
  end
`endif

  assign fft_reset  = fft_reset_q;
  assign reg_addr   = reg_addr_q;
  assign pt_idx     = pt_idx_q;
  assign pt_done    = pt_done_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;
  assign tmo_err    = tmo_err_q;

endmodule
